// File: rtl/tt_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// tt_sweep_checker_if
// Bundles the sweep request, the stimulus/response path to the sub-circuit
// under test and the result signals of tt_sweep_checker.
//   master : the side that requests sweeps and closes the loop through the
//            sub-circuit (drives start, golden_tt, resp)
//   slave  : the checker itself (drives stim, busy, done, tt_out, match,
//            mismatch_idx)
// Signals:
//   start        request a sweep (accepted only while busy=0)
//   golden_tt    expected truth table, captured on the accepting edge
//   stim         registered input pattern to the sub-circuit (stim[0] = n_1)
//   resp         single-bit sub-circuit output
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle pulse, results valid from this cycle
//   tt_out       extracted truth table, bit k = resp while stim == k
//   match        tt_out equals the captured golden table
//   mismatch_idx lowest differing index, 0 when match=1
// ---------------------------------------------------------------------------
interface tt_sweep_checker_if #(
  parameter int NUM_IN = 4
) ();
  localparam int TT_W = 2 ** NUM_IN;

  logic              start;
  logic [TT_W-1:0]   golden_tt;
  logic [NUM_IN-1:0] stim;
  logic              resp;
  logic              busy;
  logic              done;
  logic [TT_W-1:0]   tt_out;
  logic              match;
  logic [NUM_IN-1:0] mismatch_idx;

  modport master (
    output start, golden_tt, resp,
    input  stim, busy, done, tt_out, match, mismatch_idx
  );

  modport slave (
    input  start, golden_tt, resp,
    output stim, busy, done, tt_out, match, mismatch_idx
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// ---------------------------------------------------------------------------
// tt_sweep_checker
// Drives every input pattern of an NUM_IN-input, single-output combinational
// sub-circuit, samples its response after SETTLE extra hold cycles, builds the
// full truth table and compares it against a golden table captured at start.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset, priority over everything else
//   bus  tt_sweep_checker_if.slave (start/golden_tt/resp in, results out)
// Parameters:
//   NUM_IN  1..6  number of sub-circuit inputs, table width TT_W = 2**NUM_IN
//   SETTLE  0..15 extra cycles each pattern is held before sampling
// ---------------------------------------------------------------------------
module tt_sweep_checker #(
  parameter int NUM_IN = 4,
  parameter int SETTLE = 1
) (
  input logic                 clk,
  input logic                 rst,
  tt_sweep_checker_if.slave   bus
);
  localparam int                TT_W     = 2 ** NUM_IN;
  localparam logic [3:0]        SETTLE_C = 4'(SETTLE);
  // The last pattern index TT_W-1 is all ones in NUM_IN bits.
  localparam logic [NUM_IN-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q,   state_d;
  logic [NUM_IN-1:0] idx_q,     idx_d;
  logic [3:0]        settle_q,  settle_d;
  logic [NUM_IN-1:0] stim_q,    stim_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic [TT_W-1:0]   gold_q,    gold_d;
  logic [TT_W-1:0]   tt_q,      tt_d;
  logic              mm_flag_q, mm_flag_d;
  logic [NUM_IN-1:0] mm_idx_q,  mm_idx_d;
  logic              match_q,   match_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    stim_d    = stim_q;
    busy_d    = busy_q;
    done_d    = done_q;
    gold_d    = gold_q;
    tt_d      = tt_q;
    mm_flag_d = mm_flag_q;
    mm_idx_d  = mm_idx_q;
    match_d   = match_q;

    unique case (state_q)
      IDLE: begin
        stim_d = '0;
        busy_d = 1'b0;
        if (bus.start) begin
          // Results of the previous sweep are held until exactly this edge.
          gold_d    = bus.golden_tt;
          tt_d      = '0;
          mm_flag_d = 1'b0;
          mm_idx_d  = '0;
          match_d   = 1'b0;
          idx_d     = '0;
          settle_d  = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (settle_q != SETTLE_C) begin
          settle_d = settle_q + 4'd1;
        end else begin
          tt_d[idx_q] = bus.resp;
          // Only the first (lowest-index) disagreement is recorded.
          if ((bus.resp != gold_q[idx_q]) && !mm_flag_q) begin
            mm_flag_d = 1'b1;
            mm_idx_d  = idx_q;
          end
          if (idx_q == IDX_LAST) begin
            // match uses the flag including this final capture.
            match_d = ~mm_flag_d;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            stim_d   = idx_q + 1'b1;
            settle_d = '0;
          end
        end
      end

      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        stim_d  = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      settle_q  <= '0;
      stim_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gold_q    <= '0;
      tt_q      <= '0;
      mm_flag_q <= 1'b0;
      mm_idx_q  <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      stim_q    <= stim_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gold_q    <= gold_d;
      tt_q      <= tt_d;
      mm_flag_q <= mm_flag_d;
      mm_idx_q  <= mm_idx_d;
      match_q   <= match_d;
    end
  end

  assign bus.stim         = stim_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.tt_out       = tt_q;
  assign bus.match        = match_q;
  assign bus.mismatch_idx = mm_idx_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_checker
// Self-checking bench for tt_sweep_checker. Instance a uses NUM_IN=4,
// SETTLE=1 with a selectable response source; instance b uses NUM_IN=2,
// SETTLE=0 with resp = stim[0] & stim[1]. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_tt_sweep_checker;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   resp_mode = 0;  // 0: circuit, 1: tied 1, 2: tied 0, 3: toggling
  logic tog = 1'b0;
  logic resp_a;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  tt_sweep_checker_if #(.NUM_IN(4)) ifa ();
  tt_sweep_checker_if #(.NUM_IN(2)) ifb ();

  tt_sweep_checker #(.NUM_IN(4), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  tt_sweep_checker #(.NUM_IN(2), .SETTLE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  always_comb begin
    case (resp_mode)
      0:       resp_a = (ifa.stim[1] ^ (ifa.stim[0] & ifa.stim[2])) & (ifa.stim[0] | ifa.stim[2]);
      1:       resp_a = 1'b1;
      2:       resp_a = 1'b0;
      default: resp_a = tog;
    endcase
  end
  assign ifa.resp = resp_a;
  assign ifb.resp = ifb.stim[0] & ifb.stim[1];

  typedef struct {
    string       name;
    logic [15:0] gold;
    int          mode;
    logic [15:0] exp_tt;
    logic        exp_match;
    logic [3:0]  exp_idx;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full sweep on instance a: clear-on-accept, latency, results, return to idle.
  task automatic run_a(input string name, input logic [15:0] gold, input int mode,
                       input logic [15:0] exp_tt, input logic exp_match, input logic [3:0] exp_idx);
    int cyc;
    @(negedge clk);
    ifa.golden_tt = gold;
    resp_mode     = mode;
    ifa.start     = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    check({name, "_clear"}, {ifa.busy, ifa.tt_out, ifa.match, ifa.mismatch_idx},
          {1'b1, 16'h0, 1'b0, 4'h0});
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (ifa.done) break;
    end
    check({name, "_latency"}, cyc, 32);
    check({name, "_tt"}, ifa.tt_out, exp_tt);
    check({name, "_match"}, ifa.match, exp_match);
    check({name, "_idx"}, ifa.mismatch_idx, exp_idx);
    @(posedge clk); #1;
    check({name, "_idle"}, {ifa.done, ifa.busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt, first, second;

    vecs[0] = '{"golden_pass",  16'h6868, 0, 16'h6868, 1'b1, 4'd0};
    vecs[1] = '{"single_fault", 16'h6869, 0, 16'h6868, 1'b0, 4'd0};
    vecs[2] = '{"multi_fault",  16'hFF7B, 1, 16'hFFFF, 1'b0, 4'd2};
    vecs[3] = '{"bit3_fault",   16'h6860, 0, 16'h6868, 1'b0, 4'd3};
    vecs[4] = '{"bit11_fault",  16'h6068, 0, 16'h6868, 1'b0, 4'd11};
    vecs[5] = '{"last_fault",   16'h8000, 2, 16'h0000, 1'b0, 4'd15};

    rst = 1'b1;
    ifa.start = 1'b0; ifa.golden_tt = '0;
    ifb.start = 1'b0; ifb.golden_tt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {ifa.stim, ifa.busy, ifa.done, ifa.tt_out, ifa.match, ifa.mismatch_idx}, 0);
    check("reset_b", {ifb.stim, ifb.busy, ifb.done, ifb.tt_out, ifb.match, ifb.mismatch_idx}, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_a(vecs[i].name, vecs[i].gold, vecs[i].mode, vecs[i].exp_tt, vecs[i].exp_match, vecs[i].exp_idx);

    // SETTLE=0, NUM_IN=2: stim steps every cycle, done after E0+4.
    @(negedge clk);
    ifb.golden_tt = 4'h8;
    ifb.start     = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    check("b_stim0", ifb.stim, 0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("b_stim%0d", i), {ifb.done, ifb.stim}, {1'b0, 2'(i)});
    end
    @(posedge clk); #1;
    check("b_done", {ifb.done, ifb.busy}, 2'b11);
    check("b_tt", ifb.tt_out, 4'h8);
    check("b_match", {ifb.match, ifb.mismatch_idx}, {1'b1, 2'd0});

    // start held for 40 cycles: one sweep, then a second at the first post-DONE IDLE edge.
    @(negedge clk);
    ifa.golden_tt = 16'h6868; resp_mode = 0; ifa.start = 1'b1;
    @(posedge clk); #1;
    done_cnt = 0; first = 0; second = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == 39) ifa.start = 1'b0;
      if (ifa.done) begin
        done_cnt++;
        if (done_cnt == 1) first = c;
        else if (done_cnt == 2) second = c;
      end
    end
    check("held_done_cnt", done_cnt, 2);
    check("held_first", first, 32);
    check("held_second", second, 66);

    // start pulsed mid-RUN with another golden: ignored.
    @(negedge clk);
    ifa.golden_tt = 16'h6868; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    done_cnt = 0; first = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 10) begin ifa.start = 1'b1; ifa.golden_tt = 16'h0000; end
      if (c == 11) ifa.start = 1'b0;
      if (ifa.done) begin done_cnt++; if (done_cnt == 1) first = c; end
    end
    check("midrun_done_cnt", done_cnt, 1);
    check("midrun_first", first, 32);
    check("midrun_result", {ifa.tt_out, ifa.match}, {16'h6868, 1'b1});

    // rst asserted while idx=7 aborts the sweep.
    @(negedge clk);
    ifa.golden_tt = 16'h6869; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("rst_pre_idx7", {ifa.busy, ifa.stim}, {1'b1, 4'd7});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_abort", {ifa.stim, ifa.busy, ifa.done, ifa.tt_out, ifa.match, ifa.mismatch_idx}, 0);
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ifa.done) done_cnt++;
    end
    check("rst_no_done", done_cnt, 0);
    run_a("after_rst", 16'h6868, 0, 16'h6868, 1'b1, 4'd0);

    // Result hold: golden_tt and resp wander, results stay put.
    run_a("hold_setup", 16'h6068, 0, 16'h6868, 1'b0, 4'd11);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ifa.golden_tt = 16'($urandom);
      resp_mode     = 3;
      @(posedge clk); #1;
      check($sformatf("hold_%0d", c), {ifa.tt_out, ifa.match, ifa.mismatch_idx},
            {16'h6868, 1'b0, 4'd11});
    end
    run_a("after_hold", 16'hFF7B, 1, 16'hFFFF, 1'b0, 4'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
